if_id_annul_register: RTL and testbench

IF/ID pipeline register that receives the synchronous annul request `reset_out` produced by `reset_handler`. The request is driven high for system reset, or for a branch in ID with annul bit I29 set. It captures fetched instruction, PC and nPC from IF, and replaces the delay-slot instruction with a NOP when an annul request arrives. If the request arrives during a stall, it is remembered until the register next loads. It also keeps a saturating count of annulled slots for debug.

---
 rtl/sparc_pipe_pkg.sv | 18 +
 rtl/sat_counter.sv | 23 ++
 rtl/if_id_annul_register.sv | 86 ++++++++
 tb/tb_if_id_annul_register.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/sparc_pipe_pkg.sv
// Shared constants and types for the SPARC integer pipeline registers.
package sparc_pipe_pkg;

    // SPARC "sethi 0,%g0", the canonical NOP placed in an annulled slot.
    localparam logic [31:0] NOP_WORD  = 32'h0100_0000;

    // Fetch restart point: PC at 0, nPC one word ahead.
    localparam logic [31:0] PC_RESET  = 32'h0000_0000;
    localparam logic [31:0] NPC_RESET = 32'h0000_0004;

    // IF/ID annul tracking: PENDING means an annul arrived while ID was
    // stalled and must be applied to the next load.
    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } annul_state_t;

endpackage : sparc_pipe_pkg

// File: rtl/sat_counter.sv
// Saturating up-counter with increment enable and async active-low clear.
// Shared by pipeline stall/flush/annul debug counters.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count up on inc, sticking at all ones instead of wrapping.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule : sat_counter

// File: rtl/if_id_annul_register.sv
// IF/ID pipeline register with delay-slot annul. An annul request from
// reset_handler replaces the instruction being loaded with a NOP; a request
// that arrives while ID is stalled is remembered and applied to the next load.
module if_id_annul_register
    import sparc_pipe_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             system_reset_n,
    input  logic             le,
    input  logic             annul_req,
    input  logic [31:0]      instr_in,
    input  logic [31:0]      pc_in,
    input  logic [31:0]      npc_in,
    output logic [31:0]      instr_out,
    output logic [31:0]      pc_out,
    output logic [31:0]      npc_out,
    output logic             valid_out,
    output logic             annul_pending,
    output logic [CNT_W-1:0] annul_count
);

    annul_state_t state;
    logic         annul_eff;
    logic         count_inc;

    // Decode whether this edge discards the incoming slot.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        annul_eff = 1'b0;
        count_inc = 1'b0;
        if (annul_req || (state == PENDING)) begin
            annul_eff = 1'b1;
        end
        if (le && annul_eff) begin
            count_inc = 1'b1;
        end
    end

    // Data bank and annul state: load or annul when le=1, remember a stalled
    // request otherwise. PENDING survives further stall cycles and does not
    // stack, so one recorded annul discards exactly one load.
    always_ff @(posedge clk or negedge system_reset_n) begin
        if (!system_reset_n) begin
            state     <= IDLE;
            instr_out <= NOP_WORD;
            pc_out    <= PC_RESET;
            npc_out   <= NPC_RESET;
            valid_out <= 1'b0;
        end else if (le) begin
            // PC/nPC load even when annulled so traps and debug see the slot.
            pc_out  <= pc_in;
            npc_out <= npc_in;
            state   <= IDLE;
            if (annul_eff) begin
                instr_out <= NOP_WORD;
                valid_out <= 1'b0;
            end else begin
                instr_out <= instr_in;
                valid_out <= 1'b1;
            end
        end else if (annul_req) begin
            state <= PENDING;
        end
    end

    // State flop is the pending flag itself; no input reaches it combinationally.
    assign annul_pending = (state == PENDING);

    sat_counter #(
        .W (CNT_W)
    ) u_annul_counter (
        .clk   (clk),
        .clr_n (system_reset_n),
        .inc   (count_inc),
        .count (annul_count)
    );

    // An annulled load always presents a NOP marked invalid.
    a_annul_gives_nop : assert property (
        @(posedge clk) (le && annul_eff) |=> (!valid_out && instr_out == NOP_WORD)
    );

endmodule : if_id_annul_register

// File: tb/tb_if_id_annul_register.sv
// Scoreboard bench for if_id_annul_register: the driver pushes hand-computed
// expected outputs per edge, a monitor pops and compares after each edge.
module tb_if_id_annul_register;

    localparam logic [31:0] NOP = 32'h0100_0000;

    typedef struct {
        bit          sel;      // 0 = main instance, 1 = 2-bit counter instance
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] npc;
        logic        valid;
        logic        pend;
        logic [7:0]  cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        system_reset_n = 1'b0;
    logic        le = 1'b0, annul_req = 1'b0;
    logic        le2 = 1'b0, annul_req2 = 1'b0;
    logic [31:0] instr_in = '0, pc_in = '0, npc_in = '0;

    logic [31:0] instr_out, pc_out, npc_out;
    logic        valid_out, annul_pending;
    logic [7:0]  annul_count;

    logic [31:0] instr_out2, pc_out2, npc_out2;
    logic        valid_out2, annul_pending2;
    logic [1:0]  annul_count2;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    if_id_annul_register #(.CNT_W(8)) dut (
        .clk            (clk),
        .system_reset_n (system_reset_n),
        .le             (le),
        .annul_req      (annul_req),
        .instr_in       (instr_in),
        .pc_in          (pc_in),
        .npc_in         (npc_in),
        .instr_out      (instr_out),
        .pc_out         (pc_out),
        .npc_out        (npc_out),
        .valid_out      (valid_out),
        .annul_pending  (annul_pending),
        .annul_count    (annul_count)
    );

    if_id_annul_register #(.CNT_W(2)) dut_sat (
        .clk            (clk),
        .system_reset_n (system_reset_n),
        .le             (le2),
        .annul_req      (annul_req2),
        .instr_in       (instr_in),
        .pc_in          (pc_in),
        .npc_in         (npc_in),
        .instr_out      (instr_out2),
        .pc_out         (pc_out2),
        .npc_out        (npc_out2),
        .valid_out      (valid_out2),
        .annul_pending  (annul_pending2),
        .annul_count    (annul_count2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic exp_t mk(input bit sel, input logic [31:0] i, p, n,
                                input logic v, pd, input logic [7:0] c);
        exp_t e;
        e.sel = sel; e.instr = i; e.pc = p; e.npc = n;
        e.valid = v; e.pend = pd; e.cnt = c;
        return e;
    endfunction

    // Drive one cycle of stimulus, queue its expected post-edge outputs.
    task automatic step(input bit sel, input logic le_v, req_v,
                        input logic [31:0] i, p, n, input exp_t e);
        le         = sel ? 1'b0 : le_v;
        annul_req  = sel ? 1'b0 : req_v;
        le2        = sel ? le_v : 1'b0;
        annul_req2 = sel ? req_v : 1'b0;
        instr_in = i; pc_in = p; npc_in = n;
        sb.push_back(e);
        @(posedge clk);
        #2;
    endtask

    // Monitor: compare the selected instance against the next expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (!e.sel) begin
                    check("instr", instr_out, e.instr);
                    check("pc", pc_out, e.pc);
                    check("npc", npc_out, e.npc);
                    check("valid", {31'b0, valid_out}, {31'b0, e.valid});
                    check("pending", {31'b0, annul_pending}, {31'b0, e.pend});
                    check("count", {24'b0, annul_count}, {24'b0, e.cnt});
                end else begin
                    check("sat_instr", instr_out2, e.instr);
                    check("sat_pc", pc_out2, e.pc);
                    check("sat_valid", {31'b0, valid_out2}, {31'b0, e.valid});
                    check("sat_pending", {31'b0, annul_pending2}, {31'b0, e.pend});
                    check("sat_count", {30'b0, annul_count2}, {24'b0, e.cnt});
                end
            end
        end
    end

    initial begin
        int drain;

        // Reset with random inputs.
        le = 1'($urandom); annul_req = 1'($urandom);
        le2 = 1'($urandom); annul_req2 = 1'($urandom);
        instr_in = $urandom; pc_in = $urandom; npc_in = $urandom;
        repeat (2) @(posedge clk);
        #2;
        check("rst_instr", instr_out, NOP);
        check("rst_pc", pc_out, 32'h0);
        check("rst_npc", npc_out, 32'h4);
        check("rst_valid", {31'b0, valid_out}, 32'h0);
        check("rst_pending", {31'b0, annul_pending}, 32'h0);
        check("rst_count", {24'b0, annul_count}, 32'h0);
        check("rst_sat_count", {30'b0, annul_count2}, 32'h0);
        system_reset_n = 1'b1;

        // Plain load, immediate annul, plain load.
        step(0, 1, 0, 32'h8200_6001, 32'h40, 32'h44, mk(0, 32'h8200_6001, 32'h40, 32'h44, 1, 0, 1'd0));
        step(0, 1, 1, 32'h9010_2005, 32'h44, 32'h48, mk(0, NOP, 32'h44, 32'h48, 0, 0, 8'd1));
        step(0, 1, 0, 32'hA004_2001, 32'h48, 32'h4C, mk(0, 32'hA004_2001, 32'h48, 32'h4C, 1, 0, 8'd1));

        // Stalled annul: request on first stall cycle, 3 more stalls (one with
        // a repeat request that must not stack), then load.
        step(0, 0, 1, 32'hDEAD_BEEF, 32'h100, 32'h104, mk(0, 32'hA004_2001, 32'h48, 32'h4C, 1, 1, 8'd1));
        step(0, 0, 0, 32'h1111_1111, 32'h200, 32'h204, mk(0, 32'hA004_2001, 32'h48, 32'h4C, 1, 1, 8'd1));
        step(0, 0, 1, 32'h2222_2222, 32'h300, 32'h304, mk(0, 32'hA004_2001, 32'h48, 32'h4C, 1, 1, 8'd1));
        step(0, 0, 0, 32'h3333_3333, 32'h400, 32'h404, mk(0, 32'hA004_2001, 32'h48, 32'h4C, 1, 1, 8'd1));
        step(0, 1, 0, 32'hC200_2000, 32'h4C, 32'h50, mk(0, NOP, 32'h4C, 32'h50, 0, 0, 8'd2));
        step(0, 1, 0, 32'h8400_8002, 32'h50, 32'h54, mk(0, 32'h8400_8002, 32'h50, 32'h54, 1, 0, 8'd2));

        // Request again while PENDING at the load edge: single annul.
        step(0, 0, 1, 32'h4444_4444, 32'h500, 32'h504, mk(0, 32'h8400_8002, 32'h50, 32'h54, 1, 1, 8'd2));
        step(0, 1, 1, 32'h8600_0003, 32'h58, 32'h5C, mk(0, NOP, 32'h58, 32'h5C, 0, 0, 8'd3));
        step(0, 1, 0, 32'h8800_0000, 32'h5C, 32'h60, mk(0, 32'h8800_0000, 32'h5C, 32'h60, 1, 0, 8'd3));

        // Reset mid-pending: asynchronous clear between edges.
        step(0, 0, 1, 32'h5555_5555, 32'h600, 32'h604, mk(0, 32'h8800_0000, 32'h5C, 32'h60, 1, 1, 8'd3));
        #1 system_reset_n = 1'b0;
        #1;
        check("midrst_pending", {31'b0, annul_pending}, 32'h0);
        check("midrst_instr", instr_out, NOP);
        check("midrst_count", {24'b0, annul_count}, 32'h0);
        #1 system_reset_n = 1'b1;
        step(0, 1, 0, 32'h8A00_0001, 32'h60, 32'h64, mk(0, 32'h8A00_0001, 32'h60, 32'h64, 1, 0, 8'd0));

        // Saturation on the 2-bit instance: 1, 2, 3, 3, 3.
        step(1, 1, 1, 32'hAAAA_0001, 32'h200, 32'h204, mk(1, NOP, 32'h200, 32'h204, 0, 0, 8'd1));
        step(1, 1, 1, 32'hAAAA_0002, 32'h204, 32'h208, mk(1, NOP, 32'h204, 32'h208, 0, 0, 8'd2));
        step(1, 1, 1, 32'hAAAA_0003, 32'h208, 32'h20C, mk(1, NOP, 32'h208, 32'h20C, 0, 0, 8'd3));
        step(1, 1, 1, 32'hAAAA_0004, 32'h20C, 32'h210, mk(1, NOP, 32'h20C, 32'h210, 0, 0, 8'd3));
        step(1, 1, 1, 32'hAAAA_0005, 32'h210, 32'h214, mk(1, NOP, 32'h210, 32'h214, 0, 0, 8'd3));

        // Main instance held throughout the saturation phase.
        check("hold_instr", instr_out, 32'h8A00_0001);
        check("hold_count", {24'b0, annul_count}, 32'h0);

        drain = 0;
        while (sb.size() > 0 && drain < 10) begin
            @(posedge clk);
            drain++;
        end
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_if_id_annul_register
